// File: rtl/disp_pkg.sv
// Shared types and button indices for the display scheduler.
package disp_pkg;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } state_t;

    localparam int NBTN       = 6;
    localparam int BTN_NEXT   = 0;
    localparam int BTN_PREV   = 1;
    localparam int BTN_MODE   = 2;
    localparam int BTN_BLANK  = 3;
    localparam int BTN_FREEZE = 4;
    localparam int BTN_CLR    = 5;

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, mismatch counter,
// debounced level and a one-cycle press pulse on the level's rising edge.
module btn_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int            CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic          level_dly;
    logic [CW-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Level follows the synced input only after DEB_CYC consecutive disagreeing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync_p1 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            level <= sync_p1;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Previous level, so a rising edge can be seen for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_dly <= 1'b0;
        end else begin
            level_dly <= level;
        end
    end

    assign press = level & ~level_dly;

endmodule

// File: rtl/disp_scheduler.sv
// Display front-end: debounced buttons drive a MANUAL/AUTO source selector,
// blanking and freeze control, and a registered source mux into Display.data.
module disp_scheduler
    import disp_pkg::*;
#(
    parameter int X        = 32,
    parameter int NSRC     = 4,
    parameter int DEB_CYC  = 1_000_000,
    parameter int SCAN_CYC = 100_000_000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NBTN-1:0]         swb,
    input  logic [NSRC*X-1:0]       src,
    output logic [X-1:0]            data,
    output logic                    enable,
    output logic [$clog2(NSRC)-1:0] sel,
    output logic                    auto_on,
    output logic                    frozen
);

    localparam int            SW    = $clog2(NSRC);
    localparam int            TW    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [TW-1:0] TLAST = TW'(SCAN_CYC - 1);

    logic [NBTN-1:0] press;
    state_t          state;
    logic [TW-1:0]   timer;
    logic            man_step;
    logic            auto_tc;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_debounce #(
            .DEB_CYC(DEB_CYC)
        ) u_deb (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (swb[i]),
            .press(press[i])
        );
    end

    assign man_step = press[BTN_NEXT] | press[BTN_PREV] | press[BTN_CLR];
    assign auto_tc  = (state == AUTO) && (timer == TLAST);

    // Mode FSM with scan timer, source index and the enable/freeze toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            auto_on <= 1'b0;
            timer   <= '0;
            sel     <= '0;
            enable  <= 1'b1;
            frozen  <= 1'b0;
        end else begin
            // A button step always wins over the timed advance.
            if (man_step) begin
                if (press[BTN_CLR]) begin
                    sel <= '0;
                end else if (press[BTN_NEXT] && !press[BTN_PREV]) begin
                    sel <= sel + SW'(1);
                end else if (press[BTN_PREV] && !press[BTN_NEXT]) begin
                    sel <= sel - SW'(1);
                end
            end else if (auto_tc) begin
                sel <= sel + SW'(1);
            end

            unique case (state)
                MANUAL: begin
                    timer <= '0;
                    if (press[BTN_MODE]) begin
                        state   <= AUTO;
                        auto_on <= 1'b1;
                    end
                end
                AUTO: begin
                    if (press[BTN_MODE]) begin
                        state   <= MANUAL;
                        auto_on <= 1'b0;
                        timer   <= '0;
                    end else if (man_step || auto_tc) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
            endcase

            if (press[BTN_BLANK]) begin
                enable <= ~enable;
            end
            if (press[BTN_FREEZE]) begin
                frozen <= ~frozen;
            end
        end
    end

    // Output register: tracks the selected source unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (!frozen) begin
            data <= src[int'(sel) * X +: X];
        end
    end

endmodule

// File: tb/tb_disp_scheduler.sv
// Directed bench for disp_scheduler with a cycle-level reference model.
module tb_disp_scheduler;
    import disp_pkg::*;

    localparam int X    = 32;
    localparam int NSRC = 4;
    localparam int DEB  = 4;
    localparam int SCAN = 8;

    localparam logic [5:0] B_NEXT  = 6'b000001;
    localparam logic [5:0] B_PREV  = 6'b000010;
    localparam logic [5:0] B_MODE  = 6'b000100;
    localparam logic [5:0] B_BLANK = 6'b001000;
    localparam logic [5:0] B_FRZ   = 6'b010000;
    localparam logic [5:0] B_CLR   = 6'b100000;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b0;
    logic [5:0]           swb   = '0;
    logic [NSRC*X-1:0]    src;
    logic [X-1:0]         data;
    logic                 enable;
    logic [1:0]           sel;
    logic                 auto_on;
    logic                 frozen;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          m_sel;
    logic [31:0] m_data;
    bit          m_auto;
    bit          m_en;
    bit          m_frz;
    int          m_dwell;
    bit          m_lvl [NBTN];
    bit          m_prs [NBTN];
    bit          hist  [NBTN][DEB+1];

    disp_scheduler #(
        .X       (X),
        .NSRC    (NSRC),
        .DEB_CYC (DEB),
        .SCAN_CYC(SCAN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .swb    (swb),
        .src    (src),
        .data   (data),
        .enable (enable),
        .sel    (sel),
        .auto_on(auto_on),
        .frozen (frozen)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] src_val(input int k);
        return 32'h1111_1111 * (k + 1);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl,
                       input logic [31:0] exp);
        check(nm, act, exp);
        check({"model_", nm}, mdl, exp);
    endtask

    task automatic m_reset();
        m_sel   = 0;
        m_data  = '0;
        m_auto  = 1'b0;
        m_en    = 1'b1;
        m_frz   = 1'b0;
        m_dwell = 0;
        for (int b = 0; b < NBTN; b++) begin
            m_lvl[b] = 1'b0;
            m_prs[b] = 1'b0;
            for (int j = 0; j <= DEB; j++) hist[b][j] = 1'b0;
        end
    endtask

    // One clock edge of the specified behaviour.
    task automatic m_step();
        logic [31:0] nd;
        int          ns;
        bit          manual;
        bit          diff;
        nd     = m_frz ? m_data : src_val(m_sel);
        manual = m_prs[BTN_NEXT] || m_prs[BTN_PREV] || m_prs[BTN_CLR];
        ns     = m_sel;
        if (m_prs[BTN_CLR])                            ns = 0;
        else if (m_prs[BTN_NEXT] && m_prs[BTN_PREV])   ns = m_sel;
        else if (m_prs[BTN_NEXT])                      ns = (m_sel + 1) % NSRC;
        else if (m_prs[BTN_PREV])                      ns = (m_sel + NSRC - 1) % NSRC;
        else if (m_auto && m_dwell == SCAN - 1)        ns = (m_sel + 1) % NSRC;
        if (!m_auto)                                   m_dwell = 0;
        else if (manual || m_dwell == SCAN - 1)        m_dwell = 0;
        else                                           m_dwell = m_dwell + 1;
        if (m_prs[BTN_MODE]) begin
            m_auto  = !m_auto;
            m_dwell = 0;
        end
        if (m_prs[BTN_BLANK])  m_en  = !m_en;
        if (m_prs[BTN_FREEZE]) m_frz = !m_frz;
        m_sel  = ns;
        m_data = nd;
        // level flips once DEB synced samples in a row disagree with it;
        // hist[b][0] is the sample still inside the synchronizer
        for (int b = 0; b < NBTN; b++) begin
            diff = 1'b1;
            for (int j = 1; j <= DEB; j++) if (hist[b][j] == m_lvl[b]) diff = 1'b0;
            m_prs[b] = diff && !m_lvl[b];
            if (diff) m_lvl[b] = !m_lvl[b];
            for (int j = DEB; j >= 1; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = swb[b];
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("cyc_sel",     32'(sel),     32'(m_sel));
                check("cyc_data",    data,         m_data);
                check("cyc_enable",  32'(enable),  32'(m_en));
                check("cyc_frozen",  32'(frozen),  32'(m_frz));
                check("cyc_auto_on", 32'(auto_on), 32'(m_auto));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input logic [5:0] m);
        swb = m;
        cyc(8);
        swb = '0;
        cyc(8);
    endtask

    task automatic apply_reset();
        swb   = '0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < NSRC; k++) src[k*X +: X] = src_val(k);

        // reset values
        cyc(2);
        lit("rst_sel",     32'(sel),     32'(m_sel),  32'd0);
        lit("rst_data",    data,         m_data,      32'd0);
        lit("rst_enable",  32'(enable),  32'(m_en),   32'd1);
        lit("rst_frozen",  32'(frozen),  32'(m_frz),  32'd0);
        lit("rst_auto_on", 32'(auto_on), 32'(m_auto), 32'd0);
        rst_n = 1'b1;

        // debounce latency and step
        swb = B_NEXT;
        cyc(6);
        lit("deb_edge5_sel", 32'(sel), 32'(m_sel), 32'd0);
        cyc(1);
        lit("deb_edge6_sel", 32'(sel), 32'(m_sel), 32'd1);
        lit("deb_edge6_data", data, m_data, 32'h1111_1111);
        cyc(1);
        lit("deb_edge7_data", data, m_data, 32'h2222_2222);
        cyc(2);
        swb = '0;
        cyc(10);
        swb = B_NEXT;
        cyc(3);
        swb = '0;
        cyc(12);
        lit("glitch_sel", 32'(sel), 32'(m_sel), 32'd1);

        // wrap-around
        apply_reset();
        for (int k = 1; k <= 4; k++) begin
            press_btn(B_NEXT);
            lit("wrap_next_sel", 32'(sel), 32'(m_sel), 32'(k % 4));
        end
        press_btn(B_PREV);
        lit("wrap_prev_sel", 32'(sel), 32'(m_sel), 32'd3);

        // auto-scan
        apply_reset();
        press_btn(B_MODE);
        lit("auto_on", 32'(auto_on), 32'(m_auto), 32'd1);
        lit("auto_sel1", 32'(sel), 32'(m_sel), 32'd1);
        cyc(8);
        lit("auto_sel2", 32'(sel), 32'(m_sel), 32'd2);
        cyc(8);
        lit("auto_sel3", 32'(sel), 32'(m_sel), 32'd3);
        cyc(8);
        lit("auto_sel0", 32'(sel), 32'(m_sel), 32'd0);
        cyc(2);
        press_btn(B_NEXT);
        lit("auto_step_sel", 32'(sel), 32'(m_sel), 32'd3);
        cyc(6);
        lit("auto_restart_hold", 32'(sel), 32'(m_sel), 32'd3);
        cyc(1);
        lit("auto_restart_adv", 32'(sel), 32'(m_sel), 32'd0);
        press_btn(B_MODE);
        lit("auto_off", 32'(auto_on), 32'(m_auto), 32'd0);
        cyc(16);
        lit("auto_off_sel", 32'(sel), 32'(m_sel), 32'd0);

        // freeze and blank
        apply_reset();
        press_btn(B_FRZ);
        lit("frz_on", 32'(frozen), 32'(m_frz), 32'd1);
        press_btn(B_NEXT);
        press_btn(B_NEXT);
        lit("frz_sel", 32'(sel), 32'(m_sel), 32'd2);
        lit("frz_data", data, m_data, 32'h1111_1111);
        swb = B_FRZ;
        cyc(7);
        lit("unfrz_flag", 32'(frozen), 32'(m_frz), 32'd0);
        lit("unfrz_data_old", data, m_data, 32'h1111_1111);
        cyc(1);
        lit("unfrz_data_new", data, m_data, 32'h3333_3333);
        cyc(1);
        swb = '0;
        cyc(8);
        press_btn(B_BLANK);
        lit("blank_en", 32'(enable), 32'(m_en), 32'd0);
        press_btn(B_NEXT);
        lit("blank_sel", 32'(sel), 32'(m_sel), 32'd3);
        lit("blank_data", data, m_data, 32'h4444_4444);

        // simultaneous buttons
        apply_reset();
        press_btn(B_NEXT);
        press_btn(B_NEXT | B_CLR);
        lit("clr_wins_sel", 32'(sel), 32'(m_sel), 32'd0);
        apply_reset();
        press_btn(B_MODE);
        swb = B_NEXT | B_PREV;
        cyc(7);
        lit("np_sel", 32'(sel), 32'(m_sel), 32'd1);
        cyc(1);
        swb = '0;
        cyc(6);
        lit("np_dwell_hold", 32'(sel), 32'(m_sel), 32'd1);
        cyc(1);
        lit("np_dwell_adv", 32'(sel), 32'(m_sel), 32'd2);
        cyc(1);
        swb = B_NEXT;
        cyc(7);
        lit("tc_step_sel", 32'(sel), 32'(m_sel), 32'd3);
        cyc(1);
        swb = '0;
        cyc(8);

        // asynchronous reset mid-dwell
        apply_reset();
        press_btn(B_NEXT);
        press_btn(B_NEXT);
        press_btn(B_FRZ);
        press_btn(B_BLANK);
        swb = B_MODE;
        cyc(7);
        lit("ar_auto", 32'(auto_on), 32'(m_auto), 32'd1);
        swb = '0;
        cyc(3);
        lit("ar_pre_sel", 32'(sel), 32'(m_sel), 32'd2);
        lit("ar_pre_frz", 32'(frozen), 32'(m_frz), 32'd1);
        lit("ar_pre_en", 32'(enable), 32'(m_en), 32'd0);
        swb = B_NEXT;
        #2;
        rst_n = 1'b0;
        #1;
        lit("ar_sel",     32'(sel),     32'(m_sel),  32'd0);
        lit("ar_data",    data,         m_data,      32'd0);
        lit("ar_enable",  32'(enable),  32'(m_en),   32'd1);
        lit("ar_frozen",  32'(frozen),  32'(m_frz),  32'd0);
        lit("ar_auto_on", 32'(auto_on), 32'(m_auto), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(6);
        lit("ar_rel_edge5", 32'(sel), 32'(m_sel), 32'd0);
        cyc(1);
        lit("ar_rel_edge6", 32'(sel), 32'(m_sel), 32'd1);
        cyc(10);
        swb = '0;
        cyc(12);
        lit("ar_one_press", 32'(sel), 32'(m_sel), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
